ddr_rw_arbiter: RTL

Shares the single DDR burst port between the camera write path (mem_wen) and the display read path (mem_ren). It sits between the frame writer / display-FIFO reader and the DDR burst controller. It accepts one burst request at a time, grants it with a one-cycle valid pulse, and drives the burst to completion. A watchdog recovers from a hung burst.

---
 rtl/ddr_arb_pkg.sv | 19 +
 rtl/ddr_arb_watchdog.sv | 29 ++
 rtl/ddr_rw_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ddr_arb_pkg.sv
// ddr_rw_arbiter shared types: FSM states, channel ids, watchdog sizing.
package ddr_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    CH_WR = 1'b0,
    CH_RD = 1'b1
  } arb_ch_e;

  localparam int unsigned TIMEOUT_CYC_DEF = 4096;
  localparam int unsigned WDOG_W          = 13;

endpackage

// File: rtl/ddr_arb_watchdog.sv
// Burst watchdog: counts open-burst cycles, flags expiry on the last
// allowed cycle so the FSM can abort on the same edge.
module ddr_arb_watchdog
  import ddr_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic ddr_clk,
  input  logic ddr_rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + WDOG_W'(1);
    end
  end

  assign expire = en && (cnt == WDOG_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ddr_rw_arbiter.sv
// Camera-write / display-read arbiter for the single DDR burst port.
// Define ARB_WR_PRIORITY_EN for fixed write priority instead of round-robin.
module ddr_rw_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned LEN_W       = 10,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              ddr_clk,
  input  logic              ddr_rstn,
  input  logic              ddr_ready,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [LEN_W-1:0]  wr_len,
  output logic              mem_wen_valid,
  input  logic              mem_ren,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              mem_ren_valid,
  output logic              wr_burst_req,
  output logic              rd_burst_req,
  output logic [ADDR_W-1:0] burst_addr,
  output logic [LEN_W-1:0]  burst_len,
  input  logic              wr_burst_finish,
  input  logic              rd_burst_finish,
  output logic              arb_busy,
  output logic              arb_timeout
);

  arb_state_e        state;
  logic              pick_wr;
  logic              pick_rd;
  logic              go;
  logic              in_burst;
  logic              wdog_exp;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

`ifdef ARB_WR_PRIORITY_EN
  assign pick_wr = mem_wen;
`else
  arb_ch_e last_grant;
  // On a tie the channel not served last goes first.
  assign pick_wr = mem_wen && (!mem_ren || last_grant == CH_RD);
`endif

  assign pick_rd  = mem_ren && !pick_wr;
  assign go       = (state == IDLE) && ddr_ready && (mem_wen || mem_ren);
  assign sel_addr = pick_wr ? wr_addr : rd_addr;
  assign sel_len  = pick_wr ? wr_len : rd_len;
  assign in_burst = (state == WR) || (state == RD);

  ddr_arb_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .ddr_clk  (ddr_clk),
    .ddr_rstn (ddr_rstn),
    .clr      (state == IDLE),
    .en       (in_burst),
    .expire   (wdog_exp)
  );

  always_ff @(posedge ddr_clk or negedge ddr_rstn) begin
    if (!ddr_rstn) begin
      state         <= IDLE;
      mem_wen_valid <= 1'b0;
      mem_ren_valid <= 1'b0;
      wr_burst_req  <= 1'b0;
      rd_burst_req  <= 1'b0;
      burst_addr    <= '0;
      burst_len     <= '0;
      arb_busy      <= 1'b0;
      arb_timeout   <= 1'b0;
`ifndef ARB_WR_PRIORITY_EN
      last_grant    <= CH_RD;
`endif
    end else begin
      mem_wen_valid <= 1'b0;
      mem_ren_valid <= 1'b0;
      arb_timeout   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            burst_addr    <= sel_addr;
            burst_len     <= sel_len;
            mem_wen_valid <= pick_wr;
            mem_ren_valid <= pick_rd;
`ifndef ARB_WR_PRIORITY_EN
            last_grant    <= pick_wr ? CH_WR : CH_RD;
`endif
            // Zero-length: grant handshake only, no burst issued.
            if (sel_len == '0) begin
              state <= GAP;
            end else begin
              arb_busy <= 1'b1;
              unique case (1'b1)
                pick_wr: begin
                  state        <= WR;
                  wr_burst_req <= 1'b1;
                end
                default: begin
                  state        <= RD;
                  rd_burst_req <= 1'b1;
                end
              endcase
            end
          end
        end
        WR: begin
          if (wr_burst_finish) begin
            wr_burst_req <= 1'b0;
            arb_busy     <= 1'b0;
            state        <= GAP;
          end else if (wdog_exp) begin
            wr_burst_req <= 1'b0;
            arb_busy     <= 1'b0;
            arb_timeout  <= 1'b1;
            state        <= GAP;
          end
        end
        RD: begin
          if (rd_burst_finish) begin
            rd_burst_req <= 1'b0;
            arb_busy     <= 1'b0;
            state        <= GAP;
          end else if (wdog_exp) begin
            rd_burst_req <= 1'b0;
            arb_busy     <= 1'b0;
            arb_timeout  <= 1'b1;
            state        <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
